// File: rtl/aes_block_loader.sv
// Byte-serial loader feeding the AES-128 core: packs 16 bytes into a block
// and holds it on a valid/ready output until the consumer takes it.
module aes_block_loader #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [127:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [4:0]   blk_len,
  output logic         blk_last
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;
  logic [4:0]   len_q, len_d;
  logic         last_q, last_d;
  logic         valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    len_d   = len_q;
    last_d  = last_q;
    valid_d = valid_q;
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          for (int k = 0; k < 16; k++) begin
            if (cnt_q == 4'(k)) data_d[127-8*k -: 8] = in_byte;
          end
          cnt_d = cnt_q + 4'd1;
          if (in_last || cnt_q == 4'd15) begin
            state_d = HOLD;
            valid_d = 1'b1;
            len_d   = {1'b0, cnt_q} + 5'd1;
            last_d  = in_last;
          end
        end
      end
      HOLD: begin
        if (blk_ready) begin
          state_d = FILL;
          cnt_d   = 4'd0;
          data_d  = {16{PAD_BYTE}};
          len_d   = 5'd0;
          last_d  = 1'b0;
          valid_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= 4'd0;
      data_q  <= {16{PAD_BYTE}};
      len_q   <= 5'd0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      len_q   <= len_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  // Held low during reset so upstream never sees a byte taken then dropped.
  assign in_ready  = rst_n & (state_q == FILL);
  assign blk_data  = data_q;
  assign blk_valid = valid_q;
  assign blk_len   = len_q;
  assign blk_last  = last_q;

endmodule
